// File: rtl/bf16_mul_pipe_if.sv
// Handshake bundle for bf16_mul_pipe: input transaction side and result side.
// No latency of its own; it only carries signals.
// in_ready/out_ready carry the backpressure between producer, block and consumer.
interface bf16_mul_pipe_if #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [16*LANES-1:0]    in_a;
  logic [16*LANES-1:0]    in_b;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [16*LANES-1:0]    out_prod;
  logic [4*LANES-1:0]     out_flags;
  logic [TAG_W-1:0]       out_tag;

  // Producer/consumer view: drives operands and out_ready, observes results.
  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_flags, out_tag
  );

  // Multiplier view.
  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_flags, out_tag
  );
endinterface

// File: rtl/bf16_mul_pipe.sv
// LANES-wide bfloat16 multiplier (DAZ/FTZ, RNE) with per-lane {NV,OF,UF,NX} flags and tag pass-through.
// Latency STAGES cycles from acceptance to out_valid; one transaction per cycle.
// Whole pipeline freezes while out_valid & !out_ready; in_ready = !out_valid | out_ready.
module bf16_mul_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  bf16_mul_pipe_if.slave bus
);

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
  } bf16_t;

  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } flags_t;

  typedef struct packed {
    logic [15:0] prod;
    flags_t      flags;
  } lane_res_t;

  typedef struct packed {
    logic                vld;
    logic [TAG_W-1:0]    tag;
    logic [16*LANES-1:0] prod;
    logic [4*LANES-1:0]  flags;
  } stage_t;

  localparam logic [15:0] QNAN = 16'h7FC0;

  // Single-lane bf16 multiply; the pipeline below only delays its result.
  function automatic lane_res_t bf16_mul(input bf16_t a, input bf16_t b);
    lane_res_t          r;
    logic               sgn;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]        p;
    logic signed [9:0]  e;
    logic [6:0]         frac;
    logic               guard, sticky, round_up;
    logic [7:0]         rnd;

    r        = '0;
    sgn      = a.s ^ b.s;
    a_nan    = (a.e == 8'hFF) && (a.m != 7'd0);
    b_nan    = (b.e == 8'hFF) && (b.m != 7'd0);
    a_inf    = (a.e == 8'hFF) && (a.m == 7'd0);
    b_inf    = (b.e == 8'hFF) && (b.m == 7'd0);
    // Subnormals collapse to zero here, silently.
    a_zero   = (a.e == 8'h00);
    b_zero   = (b.e == 8'h00);
    p        = {8'h00, 1'b1, a.m} * {8'h00, 1'b1, b.m};
    e        = $signed({2'b00, a.e}) + $signed({2'b00, b.e}) - 10'sd127;
    frac     = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    round_up = 1'b0;
    rnd      = '0;

    if (a_nan || b_nan) begin
      r.prod     = QNAN;
      // Only a signalling NaN (quiet bit clear) raises invalid.
      r.flags.nv = (a_nan && !a.m[6]) || (b_nan && !b.m[6]);
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      r.prod     = QNAN;
      r.flags.nv = 1'b1;
    end else if (a_inf || b_inf) begin
      r.prod = {sgn, 8'hFF, 7'd0};
    end else if (a_zero || b_zero) begin
      r.prod = {sgn, 15'd0};
    end else begin
      // Normalise: significand product lies in [1,4).
      if (p[15]) begin
        frac   = p[14:8];
        guard  = p[7];
        sticky = |p[6:0];
        e      = e + 10'sd1;
      end else begin
        frac   = p[13:7];
        guard  = p[6];
        sticky = |p[5:0];
      end
      // Round to nearest, ties to even.
      round_up = guard && (sticky || frac[0]);
      rnd      = {1'b0, frac} + {7'd0, round_up};
      if (rnd[7]) begin
        e    = e + 10'sd1;
        frac = 7'd0;
      end else begin
        frac = rnd[6:0];
      end

      if (e >= 10'sd255) begin
        r.prod     = {sgn, 8'hFF, 7'd0};
        r.flags.of = 1'b1;
        r.flags.nx = 1'b1;
      end else if (e <= 10'sd0) begin
        r.prod     = {sgn, 15'd0};
        r.flags.uf = 1'b1;
        r.flags.nx = 1'b1;
      end else begin
        r.prod     = {sgn, e[7:0], frac};
        r.flags.nx = guard || sticky;
      end
    end
    return r;
  endfunction

  lane_res_t           lane_res [LANES];
  logic [16*LANES-1:0] comb_prod;
  logic [4*LANES-1:0]  comb_flags;
  stage_t              stage_in;
  stage_t              pipe [STAGES];
  logic                advance;

  // Every lane evaluates the same function on its own operand slice.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_res[l]               = bf16_mul(bus.in_a[16*l +: 16], bus.in_b[16*l +: 16]);
    assign comb_prod[16*l +: 16]     = lane_res[l].prod;
    assign comb_flags[4*l +: 4]      = lane_res[l].flags;
  end

  // The pipeline moves only when the output slot is empty or being drained.
  assign advance     = !pipe[STAGES-1].vld || bus.out_ready;
  assign bus.in_ready = advance;

  // Bundle the freshly computed transaction for the first stage register.
  always_comb begin
    stage_in       = '0;
    stage_in.vld   = bus.in_valid;
    stage_in.tag   = bus.in_tag;
    stage_in.prod  = comb_prod;
    stage_in.flags = comb_flags;
  end

  // Shift register of stages; bubbles shift along with valid entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        pipe[i] <= '0;
      end
    end else if (advance) begin
      pipe[0] <= stage_in;
      for (int i = 1; i < STAGES; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign bus.out_valid = pipe[STAGES-1].vld;
  assign bus.out_prod  = pipe[STAGES-1].prod;
  assign bus.out_flags = pipe[STAGES-1].flags;
  assign bus.out_tag   = pipe[STAGES-1].tag;

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Directed bench for bf16_mul_pipe: hand-computed vectors, backpressure, bubbles, mid-stream reset.
// Inputs change on the falling edge; outputs are sampled 1ns after it.
// Results are compared against constants or a 1.0*x identity model.
module tb_bf16_mul_pipe;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bf16_mul_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

  bf16_mul_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] stream_b(input int i);
    logic [15:0] k;
    k = i[15:0];
    return {16'h4100 + k, 16'h40C0 + k, 16'h4040 + k, 16'h3F00 + k};
  endfunction

  // Send one transaction into an idle pipe and check what emerges.
  task automatic run_vec(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag, input logic [63:0] exp_prod, input logic [15:0] exp_flags);
    int lat;
    @(negedge clk);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({name, "_in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    #1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({name, "_lat"}, lat, STAGES);
    chk({name, "_prod"}, bus.out_prod, exp_prod);
    chk({name, "_flags"}, bus.out_flags, exp_flags);
    chk({name, "_tag"}, bus.out_tag, tag);
  endtask

  initial begin
    int          sent, rcv, cyc, nstall, lat;
    logic        held;
    logic [63:0] hp;
    logic [3:0]  ht;
    logic        vin [8];

    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_prod", bus.out_prod, 0);
    chk("rst_out_flags", bus.out_flags, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // Basic products: 1*2, 1.5*1.5, -1*3, 0*10
    run_vec("basic", {16'h0000, 16'hBF80, 16'h3FC0, 16'h3F80},
                     {16'h4120, 16'h4040, 16'h3FC0, 16'h4000},
                     4'hA, 64'h0000_C040_4010_4000, 16'h0000);
    // Rounding with sticky, inf*0, sNaN, qNaN
    run_vec("special", {16'h7FC1, 16'h7F81, 16'h7F80, 16'h3F81},
                       {16'h3F80, 16'h3F80, 16'h0000, 16'h3F81},
                       4'h3, 64'h7FC0_7FC0_7FC0_3F82, 16'h0881);
    // Overflow, underflow, DAZ input, underflow to negative zero
    run_vec("range", {16'h8080, 16'h0001, 16'h0080, 16'h7F7F},
                     {16'h3F00, 16'h3F80, 16'h0080, 16'h4000},
                     4'h6, 64'h8000_0000_0000_7F80, 16'h3035);
    // Tie rounds up to even, tie stays even, rounding carry-out, -inf*2
    run_vec("ties", {16'hFF80, 16'h3FB5, 16'h3F83, 16'h3F81},
                    {16'h4000, 16'h3FB5, 16'h3FC0, 16'h3FC0},
                    4'h9, 64'hFF80_4000_3FC4_3FC2, 16'h0111);
    // -0*1, inf*subnormal, qNaN*sNaN, 2*-2
    run_vec("mixed", {16'h4000, 16'hFFC0, 16'h7F80, 16'h8000},
                     {16'hC000, 16'h7F81, 16'h8001, 16'h3F80},
                     4'hF, 64'hC080_7FC0_7FC0_8000, 16'h0880);

    @(negedge clk);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Backpressure: 10 back-to-back, consumer stalls cycles 3..6
    sent   = 0;
    rcv    = 0;
    cyc    = 0;
    nstall = 0;
    held   = 1'b0;
    hp     = '0;
    ht     = '0;
    while (rcv < 10 && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc <= 6);
      bus.in_valid  = (sent < 10);
      bus.in_tag    = sent[3:0];
      bus.in_a      = {4{16'h3F80}};
      bus.in_b      = stream_b(sent);
      #1;
      if (held) begin
        chk("bp_hold_valid", bus.out_valid, 1);
        chk("bp_hold_prod", bus.out_prod, hp);
        chk("bp_hold_tag", bus.out_tag, ht);
      end
      held = 1'b0;
      if (bus.out_valid && !bus.out_ready) begin
        nstall++;
        chk("bp_in_ready_low", bus.in_ready, 0);
        held = 1'b1;
        hp   = bus.out_prod;
        ht   = bus.out_tag;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_tag", bus.out_tag, rcv);
        chk("bp_prod", bus.out_prod, stream_b(rcv));
        chk("bp_flags", bus.out_flags, 0);
        rcv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_count", rcv, 10);
    chk("bp_stall_cycles", nstall, 4);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_no_dup", bus.out_valid, 0);

    // Bubbles: in_valid 1,0,1,0 reappears STAGES cycles later
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.in_valid  = (c < 4) && (c % 2 == 0);
      bus.in_tag    = 4'(c);
      bus.in_a      = {4{16'h3F80}};
      bus.in_b      = {4{16'h4000}};
      bus.out_ready = 1'b1;
      #1;
      vin[c] = bus.in_valid;
      chk("bub_valid", bus.out_valid, (c >= STAGES) ? vin[c-STAGES] : 1'b0);
      if (bus.out_valid) chk("bub_tag", bus.out_tag, 4'(c - STAGES));
    end

    // Reset with STAGES transactions in flight
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_tag   = 4'hC;
    bus.in_a     = {4{16'h3F80}};
    bus.in_b     = {4{16'h4040}};
    @(negedge clk);
    bus.in_tag = 4'hD;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_prod", bus.out_prod, 0);
    chk("mid_rst_flags", bus.out_flags, 0);
    chk("mid_rst_tag", bus.out_tag, 0);
    rst           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 4'h5;
    bus.in_a      = {16'h0000, 16'hBF80, 16'h3FC0, 16'h3F80};
    bus.in_b      = {16'h4120, 16'h4040, 16'h3FC0, 16'h4000};
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk("post_rst_tag", bus.out_tag, 4'h5);
    chk("post_rst_lat", lat, STAGES);
    chk("post_rst_prod", bus.out_prod, 64'h0000_C040_4010_4000);
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_drain", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
